simple_dual_burst_reader: RTL and testbench

//  Read-side engine for the simple dual-port RAM. Accepts a burst command (start address, word count),

---
 rtl/simple_dual_burst_reader_pkg.sv | 12 +
 rtl/simple_dual_burst_reader_rd_skid_fifo.sv | 59 +++++
 rtl/simple_dual_burst_reader.sv | 106 ++++++++++
 tb/tb_simple_dual_burst_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/simple_dual_burst_reader_pkg.sv
// Shared defaults and FSM state type for the simple dual-port RAM burst reader.
package simple_dual_pkg;
  localparam int unsigned WIDTH_DEF      = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned LEN_WIDTH_DEF  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/simple_dual_burst_reader_rd_skid_fifo.sv
// Two-entry FIFO holding {last, data} read beats; entry 0 is always the head.
module rd_skid_fifo #(
  parameter int unsigned W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= '0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    case ({push_i, do_pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = din_i;
        else                 mem1_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; new word lands behind the survivor.
        if (count_q == 2'd1) begin
          mem0_d = din_i;
        end else begin
          mem0_d = mem1_q;
          mem1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  assign dout_o  = mem0_q;
  assign count_o = count_q;
endmodule

// File: rtl/simple_dual_burst_reader.sv
// Burst read engine: issues RAM port-B reads with credit flow control and streams
// the returned words out on a valid/ready interface with a last flag.
module simple_dual_burst_reader
  import simple_dual_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clkb,
  input  logic                  rstb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [WIDTH-1:0]      ram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [1:0]            fifo_count;
  logic [WIDTH:0]        fifo_dout;
  logic                  pop_c;
  logic                  issue_c;
  logic [2:0]            occ_c;

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Issue a read only if the FIFO can still absorb it after this cycle's pop.
  always_comb begin
    pop_c   = m_valid && m_ready;
    occ_c   = 3'(fifo_count) + 3'(inflight_q);
    issue_c = (state_q == READ) && ((occ_c - 3'(pop_c)) < 3'd2);
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    inflight_d      = issue_c;
    inflight_last_d = issue_c && (remain_q == LEN_WIDTH'(1));
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          if (cmd_len != '0) state_d = READ;
        end
      end
      READ: begin
        if (issue_c) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_c && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM data is only valid the cycle after enb, so capture it unconditionally then.
  rd_skid_fifo #(.W(WIDTH + 1)) u_fifo (
    .clk_i   (clkb),
    .rst_i   (rstb),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, ram_doutb}),
    .pop_i   (pop_c),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  assign ram_enb   = issue_c;
  assign ram_addrb = addr_q;
  assign m_valid   = (fifo_count != 2'd0);
  assign m_data    = fifo_dout[WIDTH-1:0];
  assign m_last    = fifo_dout[WIDTH];
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_simple_dual_burst_reader.sv
// Bench for simple_dual_burst_reader: directed latency/wrap/backpressure/reset cases
// plus random bursts against a queue-based scoreboard.
module tb_simple_dual_burst_reader;
  localparam int DEPTH = 1024;

  logic        clkb      = 1'b0;
  logic        rstb      = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_addr  = '0;
  logic [10:0] cmd_len   = '0;
  logic        ram_enb;
  logic [9:0]  ram_addrb;
  logic [31:0] ram_doutb = '0;
  logic        m_valid;
  logic        m_ready   = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;

  simple_dual_burst_reader dut (
    .clkb(clkb), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
    .ram_doutb(ram_doutb), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  always #5 clkb = ~clkb;

  function automatic logic [31:0] word_at(input int a);
    return 32'(a) * 32'h01010101;
  endfunction

  // RAM port B: registered read, output held while enb is low.
  logic [31:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = word_at(i);
  always @(posedge clkb) if (ram_enb) ram_doutb <= mem[ram_addrb];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Consumer ready: held level or a coin flip every cycle.
  int   ready_mode = 0;
  logic ready_val  = 1'b1;
  always @(posedge clkb) begin
    #1;
    m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Scoreboard: expected beats queued at command acceptance, consumed on transfer.
  logic [32:0] expq[$];
  logic [32:0] mon_e;
  int          beat_cnt = 0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge clkb) begin
    if (rstb) begin
      expq.delete();
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", 64'({m_last, m_data}), 64'({pl, pd}));
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("extra_beat", 64'(1), 64'(0));
        end else begin
          mon_e = expq.pop_front();
          chk("beat", 64'({m_last, m_data}), 64'(mon_e));
        end
        beat_cnt++;
      end
      if (cmd_valid && cmd_ready)
        for (int k = 0; k < int'(cmd_len); k++)
          expq.push_back({(k == int'(cmd_len) - 1), word_at((int'(cmd_addr) + k) % DEPTH)});
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end
  end

  logic       tr_enb [16];
  logic       tr_val [16];
  logic       tr_last[16];
  logic       tr_busy[16];
  logic       tr_rdy [16];
  logic [9:0] tr_addr[16];

  // Record cycles 1..n after the acceptance edge (sampled mid-cycle).
  task automatic trace(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clkb);
      tr_enb[c] = ram_enb; tr_val[c] = m_valid; tr_last[c] = m_last;
      tr_busy[c] = busy; tr_rdy[c] = cmd_ready; tr_addr[c] = ram_addrb;
    end
  endtask

  function automatic logic [15:0] vec(input int sel, input int n);
    logic [15:0] v = '0;
    for (int c = 1; c <= n; c++)
      case (sel)
        0: v[c-1] = tr_enb[c];
        1: v[c-1] = tr_val[c];
        2: v[c-1] = tr_last[c];
        3: v[c-1] = tr_busy[c];
        default: v[c-1] = tr_rdy[c];
      endcase
    return v;
  endfunction

  task automatic send(input logic [9:0] a, input logic [10:0] l);
    @(posedge clkb); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(posedge clkb); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || m_valid || expq.size() != 0) && n < 6000) begin
      @(negedge clkb);
      n++;
    end
    chk(tag, 64'(n < 6000), 64'(1));
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beat_cnt < target && n < 500) begin
      @(posedge clkb);
      n++;
    end
    chk("beats_to", 64'(n < 500), 64'(1));
  endtask

  initial begin
    int b0;
    int l;
    // Reset held three edges
    repeat (3) @(posedge clkb);
    @(negedge clkb);
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_enb", 64'(ram_enb), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_data", 64'({m_last, m_data}), 64'(0));
    chk("rst_addrb", 64'(ram_addrb), 64'(0));
    @(posedge clkb); #1 rstb = 1'b0;
    @(negedge clkb);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Basic burst latency and framing
    b0 = beat_cnt;
    send(10'h005, 11'd4);
    trace(8);
    chk("b_enb", 64'(vec(0, 8)), 64'(16'b0000_1111));
    chk("b_valid", 64'(vec(1, 8)), 64'(16'b0011_1100));
    chk("b_last", 64'(vec(2, 8)), 64'(16'b0010_0000));
    chk("b_cmd_ready", 64'(vec(4, 8)), 64'(16'b1100_0000));
    for (int c = 1; c <= 4; c++) chk("b_addr", 64'(tr_addr[c]), 64'(5 + c - 1));
    wait_idle("b_idle");
    chk("b_count", 64'(beat_cnt - b0), 64'(4));

    // Address wrap
    b0 = beat_cnt;
    send(10'h3FE, 11'd4);
    trace(6);
    chk("w_enb", 64'(vec(0, 6)), 64'(16'b00_1111));
    chk("w_a0", 64'(tr_addr[1]), 64'(10'h3FE));
    chk("w_a1", 64'(tr_addr[2]), 64'(10'h3FF));
    chk("w_a2", 64'(tr_addr[3]), 64'(10'h000));
    chk("w_a3", 64'(tr_addr[4]), 64'(10'h001));
    wait_idle("w_idle");
    chk("w_count", 64'(beat_cnt - b0), 64'(4));

    // Backpressure: five stalled cycles after the second beat
    b0 = beat_cnt;
    send(10'h010, 11'd8);
    wait_beats(b0 + 2);
    ready_val = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clkb);
      if (s >= 2) begin
        chk("bp_enb", 64'(ram_enb), 64'(0));
        chk("bp_valid", 64'(m_valid), 64'(1));
      end
    end
    ready_val = 1'b1;
    wait_idle("bp_idle");
    chk("bp_count", 64'(beat_cnt - b0), 64'(8));

    // Empty burst
    b0 = beat_cnt;
    send(10'h020, 11'd0);
    trace(4);
    chk("e_enb", 64'(vec(0, 4)), 64'(0));
    chk("e_valid", 64'(vec(1, 4)), 64'(0));
    chk("e_busy", 64'(vec(3, 4)), 64'(0));
    chk("e_cmd_ready", 64'(vec(4, 4)), 64'(16'b1111));
    chk("e_count", 64'(beat_cnt - b0), 64'(0));

    // Reset mid-burst, then a fresh short burst
    b0 = beat_cnt;
    send(10'h000, 11'd16);
    wait_beats(b0 + 2);
    #1 rstb = 1'b1;
    @(posedge clkb); #1 rstb = 1'b0;
    @(negedge clkb);
    chk("r_valid", 64'(m_valid), 64'(0));
    chk("r_busy", 64'(busy), 64'(0));
    chk("r_enb", 64'(ram_enb), 64'(0));
    b0 = beat_cnt;
    send(10'h100, 11'd2);
    trace(6);
    chk("r2_valid", 64'(vec(1, 6)), 64'(16'b00_1100));
    chk("r2_last", 64'(vec(2, 6)), 64'(16'b00_1000));
    wait_idle("r2_idle");
    chk("r2_count", 64'(beat_cnt - b0), 64'(2));

    // Random bursts with random consumer stalls
    ready_mode = 1;
    for (int i = 0; i < 25; i++) begin
      l  = (i == 12) ? 1100 : int'($urandom_range(0, 40));
      b0 = beat_cnt;
      send(10'($urandom_range(0, DEPTH - 1)), 11'(l));
      wait_idle("rnd_idle");
      chk("rnd_count", 64'(beat_cnt - b0), 64'(l));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
